// File: rtl/vga_timing_rx_if.sv
// ----------------------------------------------------------------------------
// vga_timing_rx_if
//   Bundle between a VGA sync source and the timing receiver.
//
//   Signals:
//     p_tick        pixel enable strobe, one clk wide (source -> receiver)
//     hsync_in      horizontal sync, active-high       (source -> receiver)
//     vsync_in      vertical sync, active-high         (source -> receiver)
//     locked        timing matches the configuration   (receiver -> source)
//     pixel_x/y     recovered column / row, 10 bit     (receiver -> source)
//     video_on      visible-area flag                  (receiver -> source)
//     h_total_meas  last measured line period, ticks   (receiver -> source)
//     v_total_meas  last measured frame period, lines  (receiver -> source)
//     timing_err    one-clk pulse on a timing check failure
//
//   Modports:
//     master  the sync source side (drives strobe and syncs)
//     slave   the receiver side (vga_timing_rx)
// ----------------------------------------------------------------------------
interface vga_timing_rx_if;
  logic       p_tick;
  logic       hsync_in;
  logic       vsync_in;
  logic       locked;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic [9:0] h_total_meas;
  logic [9:0] v_total_meas;
  logic       timing_err;

  modport master (
    output p_tick, hsync_in, vsync_in,
    input  locked, pixel_x, pixel_y, video_on,
    input  h_total_meas, v_total_meas, timing_err
  );

  modport slave (
    input  p_tick, hsync_in, vsync_in,
    output locked, pixel_x, pixel_y, video_on,
    output h_total_meas, v_total_meas, timing_err
  );
endinterface

// File: rtl/vga_timing_rx.sv
// ----------------------------------------------------------------------------
// vga_timing_rx
//   Receive side of a VGA sync interface. Samples hsync/vsync on the pixel
//   enable strobe, recovers pixel_x/pixel_y/video_on locally, measures the
//   line and frame periods plus both sync widths, and reports lock once the
//   measured timing has matched the configured timing for LOCK_FRAMES
//   consecutive frames.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous reset, active-low
//     bus    vga_timing_rx_if.slave
//              in : p_tick, hsync_in, vsync_in
//              out: locked, pixel_x, pixel_y, video_on,
//                   h_total_meas, v_total_meas, timing_err
//
//   Build option:
//     VGA_RX_INSYNC_EN  when defined, hsync_in/vsync_in pass through 2-flop
//                       synchronizers (+2 clk input latency) for sources not
//                       on clk. When undefined they are sampled directly.
//
//   All state advances only on clk edges with p_tick=1, except timing_err,
//   which is a single-clk pulse.
// ----------------------------------------------------------------------------
module vga_timing_rx #(
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_W     = 96,
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_W     = 2,
  parameter int unsigned V_DISP       = 480,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_rx_if.slave   bus
);

  localparam logic [9:0] H_TOT_C  = 10'(H_TOTAL);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SS_C   = 10'(H_SYNC_START);
  localparam logic [9:0] H_SW_C   = 10'(H_SYNC_W);
  localparam logic [9:0] H_DISP_C = 10'(H_DISP);
  localparam logic [9:0] V_TOT_C  = 10'(V_TOTAL);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SS_C   = 10'(V_SYNC_START);
  localparam logic [9:0] V_SW_C   = 10'(V_SYNC_W);
  localparam logic [9:0] V_DISP_C = 10'(V_DISP);
  localparam logic [2:0] LOCK_C   = 3'(LOCK_FRAMES);
  localparam logic [9:0] SAT_C    = 10'h3FF;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic hs_s;
  logic vs_s;

`ifdef VGA_RX_INSYNC_EN
  logic [1:0] hs_sync_q;
  logic [1:0] vs_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sync_q <= 2'b00;
      vs_sync_q <= 2'b00;
    end else begin
      hs_sync_q <= {hs_sync_q[0], bus.hsync_in};
      vs_sync_q <= {vs_sync_q[0], bus.vsync_in};
    end
  end

  assign hs_s = hs_sync_q[1];
  assign vs_s = vs_sync_q[1];
`else
  assign hs_s = bus.hsync_in;
  assign vs_s = bus.vsync_in;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;

  logic       hs_prev_q, vs_prev_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] h_per_q, h_per_d;
  logic [9:0] hw_cnt_q, hw_cnt_d;
  logic [9:0] v_per_q, v_per_d;
  logic [9:0] vw_cnt_q, vw_cnt_d;
  logic [9:0] h_meas_q, h_meas_d;
  logic [9:0] v_meas_q, v_meas_d;
  logic       h_seen_q, h_seen_d;
  logic [2:0] good_cnt_q, good_cnt_d;

  logic       locked_q, locked_d;
  logic       video_on_q, video_on_d;
  logic       timing_err_q, timing_err_d;

  // --------------------------------------------------------------------------
  // Edge detection and timing checks
  // --------------------------------------------------------------------------
  logic h_rise, h_fall, v_rise, v_fall;
  logic x_wrap;
  logic err_h_per, err_h_w, err_v_per, err_v_w;
  logic err_any;

  assign h_rise = bus.p_tick &  hs_s & ~hs_prev_q;
  assign h_fall = bus.p_tick & ~hs_s &  hs_prev_q;
  assign v_rise = bus.p_tick &  vs_s & ~vs_prev_q;
  assign v_fall = bus.p_tick & ~vs_s &  vs_prev_q;

  // An hsync rise reloads pixel_x, so it never counts as a wrap.
  assign x_wrap = bus.p_tick & ~h_rise & (x_q == H_LAST_C);

  // The line-period check is meaningless until a full line has been seen
  // since the last return to SEARCH, hence the h_seen qualifier.
  assign err_h_per = h_rise & h_seen_q & (h_per_q  != H_TOT_C);
  assign err_h_w   = h_fall &            (hw_cnt_q != H_SW_C);
  assign err_v_per = v_rise &            (v_per_q  != V_TOT_C);
  assign err_v_w   = v_fall &            (vw_cnt_q != V_SW_C);

  assign err_any = (state_q != S_SEARCH) &
                   (err_h_per | err_h_w | err_v_per | err_v_w);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: asynchronous active-low reset -- rst_n is in the sensitivity list so
  // the flops clear immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_SEARCH;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SEARCH: if (v_rise && h_seen_q) state_d = S_TRACK;
      S_TRACK: begin
        // An error on this tick wins over a good-frame increment.
        if (err_any)
          state_d = S_SEARCH;
        else if (v_rise && (good_cnt_q + 3'd1 == LOCK_C))
          state_d = S_LOCKED;
      end
      S_LOCKED: if (err_any) state_d = S_SEARCH;
      default:  state_d = S_SEARCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (registered below, so they follow the sampling tick by 1 clk)
  // --------------------------------------------------------------------------
  always_comb begin
    locked_d     = (state_d == S_LOCKED);
    video_on_d   = locked_d && (x_d < H_DISP_C) && (y_d < V_DISP_C);
    timing_err_d = err_any;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    h_per_d    = h_per_q;
    hw_cnt_d   = hw_cnt_q;
    v_per_d    = v_per_q;
    vw_cnt_d   = vw_cnt_q;
    h_meas_d   = h_meas_q;
    v_meas_d   = v_meas_q;
    h_seen_d   = h_seen_q;
    good_cnt_d = good_cnt_q;

    if (bus.p_tick) begin
      // Recovered column: hsync rise re-anchors it to the sync position.
      if (h_rise)      x_d = H_SS_C;
      else if (x_wrap) x_d = 10'd0;
      else             x_d = x_q + 10'd1;

      // Recovered row: vsync rise has priority over the line advance.
      if (v_rise)      y_d = V_SS_C;
      else if (x_wrap) y_d = (y_q == V_LAST_C) ? 10'd0 : y_q + 10'd1;

      // Line period, counted from 1 on the rise tick.
      if (h_rise) begin
        h_meas_d = h_per_q;
        h_per_d  = 10'd1;
      end else if (h_per_q != SAT_C) begin
        h_per_d  = h_per_q + 10'd1;
      end

      // hsync high width; compared on the falling tick.
      if (h_rise)                         hw_cnt_d = 10'd1;
      else if (hs_s && hw_cnt_q != SAT_C) hw_cnt_d = hw_cnt_q + 10'd1;

      // Frame period in hsync rises. A coincident hsync rise belongs to the
      // frame that starts on this tick.
      if (v_rise) begin
        v_meas_d = v_per_q;
        v_per_d  = h_rise ? 10'd1 : 10'd0;
      end else if (h_rise && v_per_q != SAT_C) begin
        v_per_d  = v_per_q + 10'd1;
      end

      // vsync high width in hsync rises; compared on the falling tick.
      if (v_rise)
        vw_cnt_d = h_rise ? 10'd1 : 10'd0;
      else if (h_rise && vs_s && vw_cnt_q != SAT_C)
        vw_cnt_d = vw_cnt_q + 10'd1;

      // h_seen restarts whenever an error drops us back to SEARCH.
      if (err_any)     h_seen_d = 1'b0;
      else if (h_rise) h_seen_d = 1'b1;

      // Good-frame counter only advances in TRACK on an error-free vsync rise.
      if (state_q == S_SEARCH || state_d == S_SEARCH)
        good_cnt_d = 3'd0;
      else if (state_q == S_TRACK && v_rise)
        good_cnt_d = good_cnt_q + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      h_per_q      <= 10'd0;
      hw_cnt_q     <= 10'd0;
      v_per_q      <= 10'd0;
      vw_cnt_q     <= 10'd0;
      h_meas_q     <= 10'd0;
      v_meas_q     <= 10'd0;
      h_seen_q     <= 1'b0;
      good_cnt_q   <= 3'd0;
      locked_q     <= 1'b0;
      video_on_q   <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      if (bus.p_tick) begin
        hs_prev_q <= hs_s;
        vs_prev_q <= vs_s;
      end
      x_q          <= x_d;
      y_q          <= y_d;
      h_per_q      <= h_per_d;
      hw_cnt_q     <= hw_cnt_d;
      v_per_q      <= v_per_d;
      vw_cnt_q     <= vw_cnt_d;
      h_meas_q     <= h_meas_d;
      v_meas_q     <= v_meas_d;
      h_seen_q     <= h_seen_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      video_on_q   <= video_on_d;
      timing_err_q <= timing_err_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.pixel_x      = x_q;
  assign bus.pixel_y      = y_q;
  assign bus.video_on     = video_on_q;
  assign bus.h_total_meas = h_meas_q;
  assign bus.v_total_meas = v_meas_q;
  assign bus.timing_err   = timing_err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_rx
//   Scoreboard bench for vga_timing_rx, run with a scaled-down raster so the
//   lock/relock scenarios fit in a short run. A source model generates the
//   sync pattern on a 1-of-2 p_tick; for each tick the expected receiver
//   state is derived from the source position and the scenario in progress,
//   pushed to a queue, and popped/compared after the sampling edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_rx;

  localparam int HT  = 40;   // line total, ticks
  localparam int HSS = 30;   // hsync start
  localparam int HSW = 5;    // hsync width
  localparam int HD  = 24;   // visible columns
  localparam int VT  = 20;   // frame total, lines
  localparam int VSS = 16;   // vsync start line
  localparam int VSW = 2;    // vsync width, lines
  localparam int VD  = 12;   // visible rows
  localparam int LF  = 2;    // lock frames

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_rx_if bus ();

  vga_timing_rx #(
    .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW), .H_DISP(HD),
    .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW), .V_DISP(VD),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit locked;
    bit err;
    bit chk_xy;
    bit vrise;
    int x;
    int y;
    int hmeas;   // -1: not checked on this tick
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Source and scenario state
  int sx = 0, sy = 0;
  bit prev_hs = 0, prev_vs = 0;
  int vr_cnt = 0;           // vsync rises since last reset/error
  bit short_armed = 0, short_done = 0;
  bit vs3_armed = 0;
  bit hold_armed = 0, hold_done = 0;
  bit hide_xy = 0;
  bit vcount_arm = 0, vcount_on = 0;
  int von_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},   bus.locked,       0);
    check({tag, "_x"},        bus.pixel_x,      0);
    check({tag, "_y"},        bus.pixel_y,      0);
    check({tag, "_video_on"}, bus.video_on,     0);
    check({tag, "_hmeas"},    bus.h_total_meas, 0);
    check({tag, "_vmeas"},    bus.v_total_meas, 0);
    check({tag, "_err"},      bus.timing_err,   0);
  endtask

  // One pixel tick followed by one idle clock.
  task automatic drive_tick(input bit hs, input bit vs);
    exp_t e, g;
    bit   hrise, vrise, vfall, planned;
    hrise   = hs && !prev_hs;
    vrise   = vs && !prev_vs;
    vfall   = !vs && prev_vs;
    planned = 0;
    e.hmeas = -1;
    if (vrise) vr_cnt++;
    if (hrise && short_done) begin
      planned = 1; e.hmeas = HT - 1; short_done = 0; hide_xy = 0;
    end
    if (hrise && hold_done) begin
      planned = 1; e.hmeas = 1023; hold_done = 0; hide_xy = 0;
    end
    if (vfall && vs3_armed) begin
      planned = 1; vs3_armed = 0;
    end
    // A check failure only reports while tracking (at least one vsync rise
    // since the last SEARCH entry); it always drops back to SEARCH.
    e.err = planned && (vr_cnt >= 1);
    if (planned) vr_cnt = 0;
    e.locked = (vr_cnt >= LF + 1);
    e.chk_xy = e.locked && !hide_xy;
    e.vrise  = vrise;
    e.x      = sx;
    e.y      = sy;
    sb.push_back(e);

    bus.p_tick   = 1'b1;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      check("locked", bus.locked, g.locked);
      check("timing_err", bus.timing_err, g.err);
      if (g.hmeas >= 0) check("h_total_meas_err", bus.h_total_meas, g.hmeas);
      if (g.chk_xy) begin
        check("pixel_x", bus.pixel_x, g.x);
        check("pixel_y", bus.pixel_y, g.y);
        check("video_on", bus.video_on, (g.x < HD) && (g.y < VD));
        check("h_total_meas", bus.h_total_meas, HT);
        check("v_total_meas", bus.v_total_meas, VT);
      end
      if (g.vrise && vcount_on) begin
        check("video_on_per_frame", von_cnt, HD * VD);
        vcount_on = 0;
      end else if (vcount_on) begin
        von_cnt += int'(bus.video_on);
      end
      if (vcount_arm && g.locked) begin
        vcount_arm = 0;
        vcount_on  = 1;
        von_cnt    = int'(bus.video_on);
      end
    end
    prev_hs = hs;
    prev_vs = vs;

    bus.p_tick = 1'b0;
    @(posedge clk);
    #1;
    check("err_idle", bus.timing_err, 0);
  endtask

  task automatic src_tick();
    int len, vw;
    bit hs, vs;
    if (hold_armed && sx == 0 && sy == 2) begin
      hold_armed = 0;
      hold_done  = 1;
      hide_xy    = 1;
      repeat (2000) drive_tick(1'b0, 1'b0);
    end
    len = (short_armed && sy == 3) ? HT - 1 : HT;
    vw  = vs3_armed ? 3 : VSW;
    hs  = (sx >= HSS) && (sx < HSS + HSW);
    vs  = (sy >= VSS) && (sy < VSS + vw);
    drive_tick(hs, vs);
    if (sx == len - 1) begin
      sx = 0;
      if (short_armed && sy == 3) begin
        short_armed = 0; short_done = 1; hide_xy = 1;
      end
      sy = (sy == VT - 1) ? 0 : sy + 1;
    end else begin
      sx++;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * HT * VT) src_tick();
  endtask

  initial begin
    bus.p_tick   = 1'b0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ideal source from reset: TRACK at 1st vsync rise, locked after 3rd.
    vcount_arm = 1;
    run_frames(4);
    check("locked_after_acq", bus.locked, 1);

    // One short line while locked, then relock.
    short_armed = 1;
    run_frames(4);
    check("locked_after_short", bus.locked, 1);

    // vsync 3 lines wide: error at vsync fall, back to SEARCH.
    vs3_armed = 1;
    run_frames(1);
    check("unlocked_after_vs3", bus.locked, 0);

    // Enter TRACK, then hold hsync low for 2000 ticks.
    run_frames(1);
    hold_armed = 1;
    run_frames(4);
    check("locked_after_hold", bus.locked, 1);

    // Reset mid-frame while locked.
    for (int i = 0; i < 2 * HT * VT && !(sx == 10 && sy == 6); i++) src_tick();
    check("reset_pos_reached", (sx == 10 && sy == 6), 1);
    check("locked_before_reset", bus.locked, 1);
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    vr_cnt  = 0;
    prev_hs = 0;
    prev_vs = 0;
    hide_xy = 0;
    run_frames(4);
    check("locked_after_reset", bus.locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
